img_scaler_nn: RTL
==================

# img_scaler_nn

Parametrised streaming video downscaler. It reduces a DE/VSYNC pixel stream of runtime size in_width × in_height to out_width × out_height using an incremental (DDA) pixel selector. An optional 2-tap horizontal averaging mode is provided. Channel count, channel depth and size-port widths are parameters. The block sits between the camera/DE-framed pixel source and downstream consumers (CNN input window, debug image dump). It replaces fixed-ratio resizing wherever arbitrary downscale ratios are needed without line buffers.

## Interface
- CH, 3, number of colour channels
- BPC, 8, bits per channel; pixel width PW = CH*BPC
- HW, 11, width of horizontal size ports
- VW, 9, width of vertical size ports

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- vsync_in  in  1  frame sync, high between frames
- de_in  in  1  data enable; one pixel per cycle while high; falling edge = end of line
- pixel_in  in  PW  channel 0 in LSBs
- in_width  in  HW  active pixels per input line
- in_height  in  VW  active lines per input frame
- out_width  in  HW  output pixels per line
- out_height  in  VW  output lines per frame
- avg_mode  in  1  0 = nearest, 1 = average selected pixel with its left neighbour
- vsync_out  out  1  vsync_in delayed 2 cycles
- de_out  out  1  strobe, high only for emitted pixels (not contiguous)
- pixel_out  out  PW  output pixel, valid when de_out
- frame_done  out  1  one-cycle pulse after last output pixel of a frame
- size_err  out  1  sticky line-length error, cleared at vsync_in

## Operation
- Sizes and avg_mode are latched on every cycle vsync_in=1; constant during the frame.
- Clamping: if out_width==0 or out_width>in_width, effective out_width=in_width. Apply the same rule to height. Upscale is not supported.
- Horizontal DDA: acc_h (HW+1 bits) is cleared on de_in rising edge. Per input pixel: s = acc_h + out_width. If s ≥ in_width, select the pixel and set acc_h = s − in_width; otherwise set acc_h = s.
- Vertical DDA: acc_v is cleared when vsync_in=1. It is evaluated once per line on de_in rising edge with the same rule using out_height/in_height. Result line_sel holds for the whole line.
- A pixel is emitted when it is selected horizontally and line_sel=1.
- This gives exactly eff_out_width pixels per line and eff_out_height lines per frame when input sizes are honoured. For 96→64, pixels x = 1,2,4,5,7,8,… are selected.
- avg_mode=1: each channel is computed as (cur + prev + 1) >> 1 with BPC+1-bit intermediate. prev is the previous input pixel of the same line. For x=0, prev = cur.
- out_line counter counts emitted lines. frame_done pulses on the de_out cycle of the last pixel of line eff_out_height−1, registered so it appears 1 cycle after that de_out. It fires at most once per frame.
- size_err is set when a de_in falling edge occurs with the line pixel count ≠ in_width. It is cleared while vsync_in=1.
- de_in asserted while vsync_in=1 is ignored.

## Timing
- Latency: pixel_in → pixel_out is exactly 2 cycles in both modes. vsync_out is matched to this.
- Reset values: de_out=0, vsync_out=0, pixel_out=0, frame_done=0, size_err=0. Accumulators, counters and latched sizes are all 0.
- Reset during a frame: outputs return to 0 immediately. The block resumes only after the next vsync_in high period; a partial frame is not continued.
- A one-cycle de_in gap inside a line counts as end of line; the next de_in starts a new line.
- acc_h never exceeds 2·2^HW − 1. No overflow is possible because out_width ≤ in_width after clamping.
- Back-to-back lines with a single de_in=0 cycle between them must be supported.

## Test plan
- 96×96 → 64×64, nearest mode, ramp pixel = x: 64 de_out per selected line. Line 0 outputs 1,2,4,5,…,95. 64 lines out, one frame_done, size_err=0.
- avg_mode=1, pixel x=2k: output at x=1 equals 1 per channel, at x=2 equals 3. First-pixel case with 1→1 sizes outputs the pixel unchanged.
- out_width=0 and out_width=200 with in_width=96: pass-through, 96 pixels per line with 2-cycle latency.
- Line of 95 pixels with in_width=96: size_err=1 until the next vsync_in, then 0. Pixel selection of the next line is unaffected.
- Assert rst_n=0 mid-line: all outputs are 0 on the same cycle. No de_out occurs until after the next vsync_in. The following frame produces the correct counts.
- Random sizes (out ≤ in ≤ 2^HW−1) over 20 frames: per-line de_out count equals out_width and per-frame line count equals out_height, checked against a reference DDA model.

Source files
------------

// File: rtl/img_scaler_nn.sv
// img_scaler_nn: streaming nearest-neighbour / 2-tap horizontal-average downscaler.
//
// A DE/VSYNC pixel stream of in_width x in_height is reduced to
// out_width x out_height by two incremental (DDA) selectors: one per pixel
// along the line and one per line along the frame. No line buffers are used.
//
// Ports:
//   clk, rst_n           pixel clock, asynchronous active-low reset
//   vsync_in             frame sync, high between frames (sizes latched then)
//   de_in, pixel_in      input pixel strobe and data (channel 0 in LSBs)
//   in_width/in_height   input frame size
//   out_width/height     requested output size (0 or > input = pass-through)
//   avg_mode             1 = average the selected pixel with its left neighbour
//   vsync_out            vsync_in delayed to match the 2-cycle pixel latency
//   de_out, pixel_out    output pixel strobe and data
//   frame_done           one-cycle pulse after the last output pixel of a frame
//   size_err             sticky: a line ended with a pixel count != in_width

// Per-channel output stage: nearest pass-through or rounded 2-tap average.
module img_scaler_nn_ch #(
    parameter int BPC = 8
) (
    input  logic [BPC-1:0] cur,
    input  logic [BPC-1:0] prev,
    input  logic           avg_mode,
    output logic [BPC-1:0] res
);
    logic [BPC:0] sum;

    always_comb begin
        sum = {1'b0, cur} + {1'b0, prev} + {{BPC{1'b0}}, 1'b1};
        res = avg_mode ? sum[BPC:1] : cur;
    end
endmodule

module img_scaler_nn #(
    parameter  int CH  = 3,
    parameter  int BPC = 8,
    parameter  int HW  = 11,
    parameter  int VW  = 9,
    localparam int PW  = CH * BPC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vsync_in,
    input  logic          de_in,
    input  logic [PW-1:0] pixel_in,
    input  logic [HW-1:0] in_width,
    input  logic [VW-1:0] in_height,
    input  logic [HW-1:0] out_width,
    input  logic [VW-1:0] out_height,
    input  logic          avg_mode,
    output logic          vsync_out,
    output logic          de_out,
    output logic [PW-1:0] pixel_out,
    output logic          frame_done,
    output logic          size_err
);
    // Latched frame configuration (output sizes stored already clamped).
    logic          armed;
    logic [HW-1:0] iw_q, ow_q;
    logic [VW-1:0] ih_q, oh_q;
    logic          avg_q;
    logic [HW-1:0] ow_eff;
    logic [VW-1:0] oh_eff;

    // Line/frame tracking state.
    logic          de_d;
    logic [HW:0]   acc_h;
    logic [VW:0]   acc_v;
    logic          line_sel;
    logic [HW:0]   cnt_h;
    logic [HW-1:0] ox;
    logic [VW-1:0] out_line;
    logic          done;
    logic [PW-1:0] last_pix;

    // Combinational per-pixel decisions.
    logic          de_v, rise, fall;
    logic [HW:0]   acc_h_base, s_h, acc_h_nxt;
    logic          hsel;
    logic [VW:0]   s_v, acc_v_nxt;
    logic          vsel_now, line_sel_cur;
    logic [HW:0]   cnt_cur, cnt_nxt;
    logic [HW-1:0] ox_cur;
    logic          emit, line_last, frm_last;
    logic [PW-1:0] prev_cur;

    // Pipeline.
    logic [2:1]               vld_pipe;
    logic [2:1]               last_pipe;
    logic [1:0]               vs_pipe;
    logic [CH-1:0][BPC-1:0]   s1_cur, s1_prev, s2_res;

    always_comb begin
        ow_eff = (out_width == '0 || out_width > in_width) ? in_width : out_width;
        oh_eff = (out_height == '0 || out_height > in_height) ? in_height : out_height;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            iw_q  <= '0;
            ow_q  <= '0;
            ih_q  <= '0;
            oh_q  <= '0;
            avg_q <= 1'b0;
        end else if (vsync_in) begin
            armed <= 1'b1;
            iw_q  <= in_width;
            ow_q  <= ow_eff;
            ih_q  <= in_height;
            oh_q  <= oh_eff;
            avg_q <= avg_mode;
        end
    end

    // A line's first pixel sees cleared accumulators/counters directly, so the
    // rising-edge pixel is handled in the same cycle without a bubble.
    always_comb begin
        de_v         = de_in & ~vsync_in & armed;
        rise         = de_v & ~de_d;
        fall         = de_d & ~de_v;

        acc_h_base   = rise ? '0 : acc_h;
        s_h          = acc_h_base + {1'b0, ow_q};
        hsel         = s_h >= {1'b0, iw_q};
        acc_h_nxt    = hsel ? s_h - {1'b0, iw_q} : s_h;

        s_v          = acc_v + {1'b0, oh_q};
        vsel_now     = s_v >= {1'b0, ih_q};
        acc_v_nxt    = vsel_now ? s_v - {1'b0, ih_q} : s_v;
        line_sel_cur = rise ? vsel_now : line_sel;

        cnt_cur      = rise ? '0 : cnt_h;
        cnt_nxt      = (&cnt_cur) ? cnt_cur : cnt_cur + 1'b1;

        ox_cur       = rise ? '0 : ox;
        prev_cur     = rise ? pixel_in : last_pix;

        emit         = de_v & hsel & line_sel_cur;
        line_last    = emit && (ox_cur == ow_q - 1'b1);
        frm_last     = line_last && (out_line == oh_q - 1'b1) && !done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d     <= 1'b0;
            acc_h    <= '0;
            acc_v    <= '0;
            line_sel <= 1'b0;
            cnt_h    <= '0;
            ox       <= '0;
            out_line <= '0;
            done     <= 1'b0;
            last_pix <= '0;
            size_err <= 1'b0;
        end else begin
            de_d <= de_v;
            if (de_v) begin
                acc_h    <= acc_h_nxt;
                cnt_h    <= cnt_nxt;
                ox       <= emit ? ox_cur + 1'b1 : ox_cur;
                last_pix <= pixel_in;
            end
            if (vsync_in) begin
                acc_v    <= '0;
                line_sel <= 1'b0;
                out_line <= '0;
                done     <= 1'b0;
                size_err <= 1'b0;
            end else begin
                if (rise) begin
                    acc_v    <= acc_v_nxt;
                    line_sel <= vsel_now;
                end
                if (line_last)
                    out_line <= out_line + 1'b1;
                if (frm_last)
                    done <= 1'b1;
                if (fall && cnt_h != {1'b0, iw_q})
                    size_err <= 1'b1;
            end
        end
    end

    // Stage 1 captures the selected pixel and its left neighbour; stage 2
    // applies the channel filter and drives the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            vs_pipe   <= '0;
            s1_cur    <= '0;
            s1_prev   <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[1], emit};
            last_pipe <= {last_pipe[1], frm_last};
            vs_pipe   <= {vs_pipe[0], vsync_in};
            if (emit) begin
                s1_cur  <= pixel_in;
                s1_prev <= prev_cur;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        img_scaler_nn_ch #(.BPC(BPC)) u_ch (
            .cur      (s1_cur[c]),
            .prev     (s1_prev[c]),
            .avg_mode (avg_q),
            .res      (s2_res[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out  <= '0;
            frame_done <= 1'b0;
        end else begin
            if (vld_pipe[1])
                pixel_out <= s2_res;
            frame_done <= vld_pipe[2] & last_pipe[2];
        end
    end

    assign de_out    = vld_pipe[2];
    assign vsync_out = vs_pipe[1];
endmodule
